// File: rtl/seg7_scan_driver_pkg.sv
// seg7_pkg: shared constants for the seven-segment scan driver.
//   SEG_W     - segment bus width ({g,f,e,d,c,b,a})
//   NIB_W     - width of one displayed hex nibble
//   SEG_TABLE - active-high segment patterns for hex digits 0..F
// No ports (package).
package seg7_pkg;

  localparam int SEG_W = 7;
  localparam int NIB_W = 4;

  localparam logic [SEG_W-1:0] SEG_TABLE [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: display bus between a data source and the scan driver.
//   en         - scan enable (0 blanks the display)
//   data       - DIGITS packed hex nibbles, nibble k = data[4k+3:4k]
//   seg        - segment outputs {g,f,e,d,c,b,a}
//   an         - digit selects
//   frame_done - one-cycle pulse at each frame start
// master: the side that drives en/data; slave: the scan driver.
interface seg7_scan_driver_if #(
  parameter int DIGITS = 4
);
  import seg7_pkg::*;

  logic                    en;
  logic [NIB_W*DIGITS-1:0] data;
  logic [SEG_W-1:0]        seg;
  logic [DIGITS-1:0]       an;
  logic                    frame_done;

  modport master (output en, data, input seg, an, frame_done);
  modport slave  (input en, data, output seg, an, frame_done);

endinterface

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble to active-high seven-segment decode.
//   nib - 4-bit value 0..F
//   seg - active-high segments {g,f,e,d,c,b,a}
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  output logic [SEG_W-1:0] seg
);

  assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed seven-segment display driver.
// A prescaler produces one tick every DIV cycles; each tick advances the
// digit index. At the start of every frame the input data is captured into a
// shadow register so a displayed frame never mixes old and new values.
// Outputs are registered and only change on ticks (or when disabled/reset).
//   clk   - system clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - seg7_scan_driver_if.slave (en, data in; seg, an, frame_done out)
// Optional build macro LEADING_ZERO_BLANK_EN: blank digits k>0 whose shadow
// nibbles k..DIGITS-1 are all zero (digit 0 is always shown).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int DIV        = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  seg7_scan_driver_if.slave bus
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW = NIB_W * DIGITS;
  localparam logic [PW-1:0]     PRE_LAST = PW'(DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  // Inactive level equals the polarity mask: all ones when active-low.
  localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{ACTIVE_LOW}};
  localparam logic [SEG_W-1:0]  SEG_OFF  = {SEG_W{ACTIVE_LOW}};

  logic [PW-1:0]     prescaler_reg, prescaler_next;
  logic [IW-1:0]     idx_reg, idx_next;
  logic [DW-1:0]     shadow_reg, shadow_next;
  logic [DIGITS-1:0] an_reg, an_next;
  logic [SEG_W-1:0]  seg_reg, seg_next;
  logic              frame_done_reg, frame_done_next;

  logic              tick;
  logic              frame_start;
  logic [NIB_W-1:0]  nibble_next;
  logic [SEG_W-1:0]  seg_hi;
  logic [DIGITS-1:0] sel_hi;
  logic              blank;

  // Decode looks ahead at the values being loaded this edge so the new digit
  // and its pattern land in the output registers together.
  assign nibble_next = shadow_next[idx_next*NIB_W +: NIB_W];

  hex_to_seg7 u_dec (
    .nib (nibble_next),
    .seg (seg_hi)
  );

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_sel
    assign sel_hi[gi] = (idx_next == IW'(gi));
  end

`ifdef LEADING_ZERO_BLANK_EN
  // upper_zero[k] = nibbles k..DIGITS-1 of the frame's shadow are all zero.
  // Bit 0 is forced low so digit 0 is never blanked.
  logic [DIGITS:0] upper_zero;
  assign upper_zero[DIGITS] = 1'b1;
  assign upper_zero[0]      = 1'b0;
  for (genvar gi = 1; gi < DIGITS; gi++) begin : g_lzb
    assign upper_zero[gi] = (shadow_next[gi*NIB_W +: NIB_W] == '0) && upper_zero[gi+1];
  end
  assign blank = upper_zero[idx_next];
`else
  assign blank = 1'b0;
`endif

  // Next-state and output logic; idx is the scan FSM state.
  always_comb begin
    prescaler_next  = prescaler_reg;
    idx_next        = idx_reg;
    shadow_next     = shadow_reg;
    an_next         = an_reg;
    seg_next        = seg_reg;
    frame_done_next = 1'b0;
    tick            = 1'b0;
    frame_start     = 1'b0;

    if (!bus.en) begin
      // Disabled: blank and park exactly as after reset; shadow is kept.
      prescaler_next = '0;
      idx_next       = IDX_LAST;
      an_next        = AN_OFF;
      seg_next       = SEG_OFF;
    end else begin
      tick           = (prescaler_reg == PRE_LAST);
      prescaler_next = tick ? '0 : prescaler_reg + 1'b1;
      if (tick) begin
        if (idx_reg == IDX_LAST) begin
          idx_next    = '0;
          frame_start = 1'b1;
          shadow_next = bus.data;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
        an_next         = blank ? AN_OFF  : (sel_hi ^ AN_OFF);
        seg_next        = blank ? SEG_OFF : (seg_hi ^ SEG_OFF);
        frame_done_next = frame_start;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler_reg  <= '0;
      idx_reg        <= IDX_LAST;
      shadow_reg     <= '0;
      an_reg         <= AN_OFF;
      seg_reg        <= SEG_OFF;
      frame_done_reg <= 1'b0;
    end else begin
      prescaler_reg  <= prescaler_next;
      idx_reg        <= idx_next;
      shadow_reg     <= shadow_next;
      an_reg         <= an_next;
      seg_reg        <= seg_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign bus.an         = an_reg;
  assign bus.seg        = seg_reg;
  assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench for seg7_scan_driver
// (DIGITS=4, DIV=4, ACTIVE_LOW=1). The stimulus process queues expected
// output snapshots tagged with the clock edge after which they must hold;
// a monitor samples on the falling edge and pops/compares them.
module tb_seg7_scan_driver;
  import seg7_pkg::*;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  seg7_scan_driver_if #(.DIGITS(DIGITS)) bus ();

  seg7_scan_driver #(
    .DIGITS     (DIGITS),
    .DIV        (DIV),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [3:0] an;
    logic [6:0] seg;
    logic       fd;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic expect_at(input int at, input logic [3:0] an, input logic [6:0] seg,
                           input logic fd, input string name);
    exp_t e;
    e.at = at; e.an = an; e.seg = seg; e.fd = fd; e.name = name;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
    #1;
  endtask

  // Monitor: compare every queued snapshot whose edge has been reached.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      n_cmp++;
      if (e.at < cyc) begin
        n_bad++;
        $display("FAIL %s: check for edge %0d skipped (now %0d)", e.name, e.at, cyc);
      end else if ({bus.an, bus.seg, bus.frame_done} !== {e.an, e.seg, e.fd}) begin
        n_bad++;
        $display("FAIL %s @%0d: got an=%b seg=%h fd=%b, expected an=%b seg=%h fd=%b",
                 e.name, cyc, bus.an, bus.seg, bus.frame_done, e.an, e.seg, e.fd);
      end else begin
        $display("check %s @%0d: an=%b seg=%h fd=%b ok", e.name, cyc, bus.an, bus.seg,
                 bus.frame_done);
      end
    end
  end

  initial begin
    bus.en   = 1'b0;
    bus.data = '0;
    rst_n    = 1'b0;

    // Reset held for edges 1..3.
    expect_at(1,  4'hF, 7'h7F, 1'b0, "reset_e1");
    expect_at(2,  4'hF, 7'h7F, 1'b0, "reset_e2");
    expect_at(3,  4'hF, 7'h7F, 1'b0, "reset_e3");
    // Released with en=1, data=1234 after edge 3; first digit at edge 7.
    expect_at(4,  4'hF, 7'h7F, 1'b0, "latency_blank_e4");
    expect_at(6,  4'hF, 7'h7F, 1'b0, "latency_blank_e6");
    expect_at(7,  4'hE, 7'h19, 1'b1, "d0_4_frame");
    expect_at(8,  4'hE, 7'h19, 1'b0, "d0_4_pulse_end");
    expect_at(10, 4'hE, 7'h19, 1'b0, "d0_4_hold");
    expect_at(11, 4'hD, 7'h30, 1'b0, "d1_3");
    // data -> ABCD after edge 12 (digit-1 slot): rest of frame unchanged.
    expect_at(15, 4'hB, 7'h24, 1'b0, "d2_2_coherent");
    expect_at(19, 4'h7, 7'h79, 1'b0, "d3_1_coherent");
    expect_at(23, 4'hE, 7'h21, 1'b1, "d0_D_frame");
    expect_at(24, 4'hE, 7'h21, 1'b0, "d0_D_hold");
    expect_at(27, 4'hD, 7'h46, 1'b0, "d1_C");
    expect_at(31, 4'hB, 7'h03, 1'b0, "d2_b");
    expect_at(35, 4'h7, 7'h08, 1'b0, "d3_A");
    // en=0 after edge 37.
    expect_at(38, 4'hF, 7'h7F, 1'b0, "disable_blank");
    expect_at(40, 4'hF, 7'h7F, 1'b0, "disable_hold");
    // en=1 after edge 41: digit 0 four edges later, shadow retained.
    expect_at(44, 4'hF, 7'h7F, 1'b0, "reenable_blank");
    expect_at(45, 4'hE, 7'h21, 1'b1, "reenable_d0_frame");
    expect_at(46, 4'hE, 7'h21, 1'b0, "reenable_d0_hold");
    expect_at(49, 4'hD, 7'h46, 1'b0, "reenable_d1");
    expect_at(53, 4'hB, 7'h03, 1'b0, "reenable_d2");
    // rst_n=0 after edge 54: nothing changes before edge 55.
    expect_at(54, 4'hB, 7'h03, 1'b0, "reset_before_edge");
    expect_at(55, 4'hF, 7'h7F, 1'b0, "reset_mid_blank");
    expect_at(56, 4'hF, 7'h7F, 1'b0, "reset_mid_hold");
    // Released after edge 56 with data=0050.
    expect_at(59, 4'hF, 7'h7F, 1'b0, "restart_blank");
    expect_at(60, 4'hE, 7'h40, 1'b1, "lz_d0_0");
    expect_at(64, 4'hD, 7'h12, 1'b0, "lz_d1_5");
`ifdef LEADING_ZERO_BLANK_EN
    expect_at(68, 4'hF, 7'h7F, 1'b0, "lz_d2_blank");
    expect_at(72, 4'hF, 7'h7F, 1'b0, "lz_d3_blank");
`else
    expect_at(68, 4'hB, 7'h40, 1'b0, "lz_d2_shown");
    expect_at(72, 4'h7, 7'h40, 1'b0, "lz_d3_shown");
`endif
    expect_at(76, 4'hE, 7'h40, 1'b1, "lz_d0_frame2");
    expect_at(77, 4'hE, 7'h40, 1'b0, "lz_d0_hold");

    wait_cyc(3);
    rst_n    = 1'b1;
    bus.en   = 1'b1;
    bus.data = 16'h1234;
    $display("stim @%0d: release reset, en=1, data=1234", cyc);

    wait_cyc(12);
    bus.data = 16'hABCD;
    $display("stim @%0d: data=ABCD", cyc);

    wait_cyc(37);
    bus.en = 1'b0;
    $display("stim @%0d: en=0", cyc);

    wait_cyc(41);
    bus.en = 1'b1;
    $display("stim @%0d: en=1", cyc);

    wait_cyc(54);
    rst_n    = 1'b0;
    bus.data = 16'h0050;
    $display("stim @%0d: rst_n=0, data=0050", cyc);

    wait_cyc(56);
    rst_n = 1'b1;
    $display("stim @%0d: rst_n=1", cyc);

    wait_cyc(80);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d checks pending, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream consumer of the 4-bit free-running counter.
- Displays up to DIGITS hex nibbles on a time-multiplexed common-anode/cathode seven-segment display; the counter's cnt drives nibble 0.
- Contains a refresh prescaler, a digit-scan state machine, a frame-synchronous shadow latch, and a registered hex-to-segment decode.

Parameters:
- DIGITS, 4, number of display digits (1..8).
- DIV, 50000, clk cycles per digit slot (>=2); prescaler width is $clog2(DIV).
- ACTIVE_LOW, 1, 1 = seg and an outputs active-low; 0 = active-high.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  scan enable; 0 blanks the display and freezes scanning.
- data  input  4*DIGITS  nibble k = data[4k+3:4k]; nibble 0 is fed from counter cnt.
- seg  output  7  segments {g,f,e,d,c,b,a}, polarity per ACTIVE_LOW.
- an  output  DIGITS  digit select, one-hot when active, polarity per ACTIVE_LOW.
- frame_done  output  1  one-cycle pulse at each frame start.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low, sampled only on the rising edge of clk. There is no asynchronous path.
- Reset state:
  - prescaler=0; idx=DIGITS-1; shadow=0.
  - an = all inactive; seg = all off; frame_done=0.
- Prescaler:
  - When en=1, counts 0..DIV-1 and wraps.
  - tick = (prescaler==DIV-1) && en.
  - When en=0, prescaler is cleared to 0.
- Scan FSM: the state is idx, 0..DIGITS-1.
  - On tick: idx <= (idx==DIGITS-1) ? 0 : idx+1.
  - On a tick where idx wraps to 0 (frame start): shadow <= data and frame_done=1 for that cycle.
  - frame_done is also asserted on the first wrap after reset or enable.
- Outputs are registered and updated on tick edges only:
  - an selects idx_next.
  - seg = decode(shadow_next[idx_next]).
  - Both hold steady for DIV cycles.
- Latency: the first digit appears DIV cycles after rst_n deassertion with en=1.
- Data coherence: data changes mid-frame are not visible until the next frame start. A displayed frame never mixes old and new values.
- Decode, active-high form:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
  - When ACTIVE_LOW=1, seg and an are bitwise inverted at the output registers.
- en falls:
  - At the next edge: an and seg go inactive, prescaler=0, idx=DIGITS-1.
  - shadow is retained.
  - On re-enable, scanning restarts exactly as after reset.
- Reset mid-frame: all state returns to reset values at the next edge, regardless of en.
- DIGITS=1: idx is constant 0; every tick is a frame start.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit k>0 is blanked (seg all off, an slot inactive) when shadow nibbles k..DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - Evaluation uses shadow only.
- Undefined: all digits are always shown, including leading zeros.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry segment pattern constant table;
  - the SEG_W=7 localparam;
  - the nibble-width constant NIB_W=4.
- One sub-module, hex_to_seg7: a combinational 4-bit to 7-bit active-high decoder. It is instantiated once on shadow_next[idx_next].
- Scan and prescaler logic stays in the top module.

Test Plan (DIGITS=4, DIV=4, ACTIVE_LOW=1):
- Reset: rst_n=0 for 3 cycles -> an=4'hF, seg=7'h7F, frame_done=0; no change until a clk edge.
- Basic scan: data=16'h1234, en=1 after reset.
  - Edge 4: an=4'b1110, seg=7'h19 (digit "4"), frame_done=1 for 1 cycle.
  - Edge 8: an=4'b1101, seg=7'h30 (digit "3").
  - Edge 12: an=4'b1011, seg=7'h24 (digit "2").
  - Edge 16: an=4'b0111, seg=7'h79 (digit "1").
  - Edge 20: wraps to digit 0.
- Coherence: data changes to 16'hABCD during digit-1 slot -> digits 2 and 3 still show "2" and "1"; the next frame shows D, C, b, A (seg 7'h21, 7'h46, 7'h03, 7'h08).
- Enable: en=0 mid-frame -> next edge an=4'hF, seg=7'h7F. en=1 -> digit 0 appears exactly 4 cycles later with frame_done=1.
- Sync reset mid-scan: rst_n=0 during digit-2 slot -> outputs blank at the following edge, not before; idx restarts as after reset.
- Leading-zero blanking: data=16'h0050.
  - With LEADING_ZERO_BLANK_EN: digits 3 and 2 are blank (an slot inactive, seg=7'h7F); digit 1 shows 7'h12 ("5"); digit 0 shows 7'h40 ("0").
  - Without the macro: all four digits are shown.
